// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Used by the load/store-multiple sequencer.
package cpu_pkg;

  localparam int NREG       = 16;
  localparam int PC_IDX     = 15;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = $clog2(NREG + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Number of set bits in a register list.
  function automatic logic [CNT_W-1:0] popcount(
    input logic [NREG-1:0] v
  );
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_prio_enc.sv
// Lowest-set-bit priority encoder.
// Picks the next register to transfer.
module prio_enc #(
  parameter int N = 16
) (
  input  logic [N-1:0] vec,
  output logic [3:0]   idx,
  output logic         any
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: walks a register list
// and moves one word per listed register.
module ldm_stm_seq #(
  parameter int DATA_W     = 32,
  parameter int NREG       = cpu_pkg::NREG,
  parameter int WORD_BYTES = cpu_pkg::WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic [NREG-1:0]   reglist,
  input  logic [DATA_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] final_addr,
  output logic [3:0]        ra,
  input  logic [DATA_W-1:0] rd,
  output logic [3:0]        wa3,
  output logic              we3,
  output logic [DATA_W-1:0] wd3,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  import cpu_pkg::*;

  seq_state_e        state_q, state_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] final_q, final_d;
  logic              load_q, load_d;

  logic [3:0] cur;
  logic       any;
  logic       xfer;
  logic       hs;
  logic       to_pc;

  prio_enc #(
    .N(NREG)
  ) u_enc (
    .vec(pending_q),
    .idx(cur),
    .any(any)
  );

  assign xfer  = (state_q == XFER);
  assign hs    = xfer & any & mem_ack;
  assign to_pc = (cur == 4'(PC_IDX));

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    load_d    = load_q;
    final_d   = final_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          final_d = base_addr
                  + DATA_W'(WORD_BYTES)
                  * DATA_W'(popcount(reglist));
          if (|reglist) begin
            pending_d = reglist;
            addr_d    = base_addr;
            load_d    = is_load;
            state_d   = XFER;
          end else begin
            state_d = DONE;
          end
        end
      end
      XFER: begin
        if (hs) begin
          pending_d = pending_q
                    & ~(NREG'(1) << cur);
          addr_d    = addr_q
                    + DATA_W'(WORD_BYTES);
          if (pending_d == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      load_q    <= 1'b0;
      final_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      load_q    <= load_d;
      final_q   <= final_d;
    end
  end

  // Outputs decoded from state; zero outside XFER.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    final_addr = final_q;
    mem_req    = xfer;
    mem_we     = xfer & ~load_q;
    mem_addr   = xfer ? addr_q : '0;
    mem_wdata  = xfer ? rd : '0;
    ra         = xfer ? cur : '0;
    wa3        = xfer ? cur : '0;
    we3        = hs & load_q & ~to_pc;
    pc_we      = hs & load_q & to_pc;
    wd3        = we3 ? mem_rdata : '0;
    pc_wdata   = pc_we ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq.
// Expected transfers queued at start, checked at handshake.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_load;
  logic [15:0] reglist;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic [31:0] final_addr;
  logic [3:0]  ra;
  logic [31:0] rd;
  logic [3:0]  wa3;
  logic        we3;
  logic [31:0] wd3;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rg;
    logic        pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rq[$];
  logic [31:0] rf[16];
  int          n_vec = 0;
  int          n_err = 0;
  int          ack_wait = 0;
  int          wcnt = 0;
  int          rcnt = 0;
  logic        held = 1'b0;
  logic [31:0] hold_addr = '0;

  always #5 clk = ~clk;

  assign rd = rf[ra];

  ldm_stm_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .is_load(is_load),
    .reglist(reglist),
    .base_addr(base_addr),
    .busy(busy),
    .done(done),
    .final_addr(final_addr),
    .ra(ra),
    .rd(rd),
    .wa3(wa3),
    .we3(we3),
    .wd3(wd3),
    .pc_we(pc_we),
    .pc_wdata(pc_wdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Memory responder: ack after ack_wait cycles.
  always @(posedge clk) begin
    #1;
    if (mem_req && rst_n) begin
      if (wcnt >= ack_wait) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (!mem_we && rq.size() > 0)
          mem_rdata = rq.pop_front();
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // Monitor: compare each completed handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("we_in_rst", {30'd0, we3, pc_we}, 0);
      held = 1'b0;
      rcnt = 0;
    end else if (mem_req) begin
      rcnt++;
      if (held)
        chk("req_hold_addr", mem_addr, hold_addr);
      if (mem_ack) begin
        chk("req_cycles", rcnt, ack_wait + 1);
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) begin
            chk("ra", {28'd0, ra}, {28'd0, e.rg});
            chk("mem_wdata", mem_wdata, e.data);
            chk("st_we", {30'd0, we3, pc_we}, 0);
          end else if (e.pc) begin
            chk("pc_we", {31'd0, pc_we}, 1);
            chk("pc_wdata", pc_wdata, e.data);
            chk("we3_pc", {31'd0, we3}, 0);
          end else begin
            chk("we3", {31'd0, we3}, 1);
            chk("wa3", {28'd0, wa3}, {28'd0, e.rg});
            chk("wd3", wd3, e.data);
            chk("pc_we_ld", {31'd0, pc_we}, 0);
          end
        end
        if (we3) rf[wa3] = wd3;
        rcnt = 0;
        held = 1'b0;
      end else begin
        chk("we_wait", {30'd0, we3, pc_we}, 0);
        held      = 1'b1;
        hold_addr = mem_addr;
      end
    end else begin
      chk("we_idle", {30'd0, we3, pc_we}, 0);
      rcnt = 0;
      held = 1'b0;
    end
  end

  task automatic run_xfer(
    input logic        ld,
    input logic [15:0] list,
    input logic [31:0] base,
    input int          wt,
    input bit          glitch
  );
    exp_t e;
    int   k;
    int   n;
    bit   got;
    k        = 0;
    ack_wait = wt;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        e.addr = base + 32'(4 * k);
        e.we   = !ld;
        e.rg   = 4'(i);
        e.pc   = ld && (i == 15);
        if (ld) begin
          e.data = 32'hA0 + 32'(16 * k);
          rq.push_back(e.data);
        end else begin
          e.data = rf[i];
        end
        sb.push_back(e);
        k++;
      end
    end
    @(negedge clk);
    start     = 1'b1;
    is_load   = ld;
    reglist   = list;
    base_addr = base;
    n         = 0;
    got       = 0;
    while (n < 200 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1 && glitch) begin
        reglist   = 16'hF0F0;
        base_addr = 32'hDEAD_0000;
        is_load   = ~ld;
      end else if (n <= 2) begin
        start = 1'b0;
      end
      if (k == 0)
        chk("no_req", {31'd0, mem_req}, 0);
      if (done) got = 1;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, got}, 1);
    if (wt == 0)
      chk("latency", n, k + 1);
    chk("final_addr", final_addr,
        base + 32'(4 * k));
    chk("busy_done", {31'd0, busy}, 1);
    chk("req_done", {31'd0, mem_req}, 0);
    @(posedge clk);
    #1;
    chk("busy_after", {31'd0, busy}, 0);
    chk("done_after", {31'd0, done}, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      rf[i] = 32'h1000_0000 + 32'(i * 32'h11);
    rst_n     = 1'b0;
    start     = 1'b0;
    is_load   = 1'b0;
    reglist   = '0;
    base_addr = '0;
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_final", final_addr, 0);
    chk("rst_ra_wa3", {24'd0, ra, wa3}, 0);
    chk("rst_we", {30'd0, we3, pc_we}, 0);
    chk("rst_wd", wd3 | pc_wdata, 0);
    chk("rst_req", {30'd0, mem_req, mem_we}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    #10;
    rst_n = 1'b1;

    run_xfer(1'b0, 16'h0013, 32'h100, 0, 0);
    run_xfer(1'b1, 16'h8006, 32'h200, 0, 0);
    chk("rf1", rf[1], 32'hA0);
    chk("rf2", rf[2], 32'hB0);
    run_xfer(1'b1, 16'h0001, 32'h300, 3, 0);
    chk("rf0", rf[0], 32'hA0);
    run_xfer(1'b0, 16'h0000, 32'h40, 0, 0);
    run_xfer(1'b0, 16'h0700, 32'h500, 0, 1);
    run_xfer(1'b0, 16'h0C03, 32'hFFFF_FFF8, 1, 0);

    // Reset after the first of three stores.
    run_rst();

    run_xfer(1'b1, 16'h0030, 32'h600, 0, 0);
    chk("rf5", rf[5], 32'hB0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  task automatic run_rst();
    exp_t e;
    ack_wait = 0;
    for (int i = 0; i < 3; i++) begin
      e.addr = 32'h700 + 32'(4 * i);
      e.we   = 1'b1;
      e.rg   = 4'(i);
      e.pc   = 1'b0;
      e.data = rf[i];
      sb.push_back(e);
    end
    @(negedge clk);
    start     = 1'b1;
    is_load   = 1'b0;
    reglist   = 16'h0007;
    base_addr = 32'h700;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_left", sb.size(), 2);
    sb.delete();
    rq.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("post_busy", {31'd0, busy}, 0);
    chk("post_final", final_addr, 0);
    chk("post_maddr", mem_addr, 0);
  endtask

endmodule
